mem_wb_skid_stage: RTL and testbench

//  Parametrised MEM->WB pipeline stage: 2-entry skid buffer with valid/ready handshake, flush and x0-write suppression.

---
 rtl/mem_wb_pkg.sv | 21 ++
 rtl/mem_wb_payload_reg.sv | 18 +
 rtl/mem_wb_skid_stage.sv | 136 +++++++++++++
 tb/tb_mem_wb_skid_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// Shared MEM->WB types: payload bundle, skid state encoding
// and the x0 register address.
package mem_wb_pkg;
  localparam int MW_DATA_W  = 32;
  localparam int MW_RADDR_W = 5;
  localparam int RADDR_ZERO = 0;

  typedef struct packed {
    logic [MW_DATA_W-1:0]  mem;
    logic [MW_DATA_W-1:0]  alu;
    logic [MW_RADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memtoreg;
  } mem_wb_payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } mem_wb_state_e;
endpackage

// File: rtl/mem_wb_payload_reg.sv
// Enable-loaded payload register, W bits, no reset.
// Ports: clk_i, en_i load strobe, d_i next payload, q_o held payload.
module mem_wb_payload_reg #(
  parameter int W = 71
) (
  input  logic         clk_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (en_i) data_q <= d_i;
  end

  assign q_o = data_q;
endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB stage: 2-entry skid buffer, valid/ready, flush, x0 write
// suppression. Ports: clk_i, rst_n_i, flush_i; in_* MEM-side payload
// and handshake; out_* WB-side head payload and handshake; wb_we_o.
// Define MEM_WB_FWD_EN to add fwd_rs1_i/fwd_rs2_i, wb_data_o,
// fwd_hit1_o and fwd_hit2_o.
module mem_wb_skid_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DATA_W-1:0]  in_mem_i,
  input  logic [DATA_W-1:0]  in_alu_i,
  input  logic [RADDR_W-1:0] in_rd_i,
  input  logic               in_regwrite_i,
  input  logic               in_memtoreg_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  out_mem_o,
  output logic [DATA_W-1:0]  out_alu_o,
  output logic [RADDR_W-1:0] out_rd_o,
  output logic               out_memtoreg_o,
`ifdef MEM_WB_FWD_EN
  input  logic [RADDR_W-1:0] fwd_rs1_i,
  input  logic [RADDR_W-1:0] fwd_rs2_i,
  output logic [DATA_W-1:0]  wb_data_o,
  output logic               fwd_hit1_o,
  output logic               fwd_hit2_o,
`endif
  output logic               wb_we_o
);
  import mem_wb_pkg::*;

  typedef struct packed {
    logic [DATA_W-1:0]  mem;
    logic [DATA_W-1:0]  alu;
    logic [RADDR_W-1:0] rd;
    logic               regwrite;
    logic               memtoreg;
  } payload_t;

  localparam int PW = $bits(payload_t);

  mem_wb_state_e state_q, state_d;
  payload_t      in_pl, main_d, main_q, skid_q;
  logic          acc, pop;
  logic          ld_main, ld_skid, sel_skid;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_ready_o  = (state_q != ST_TWO);
  assign acc = in_valid_i & in_ready_o;
  assign pop = out_valid_o & out_ready_i;

  always_comb begin
    in_pl.mem      = in_mem_i;
    in_pl.alu      = in_alu_i;
    in_pl.rd       = in_rd_i;
    in_pl.regwrite = in_regwrite_i &
      (in_rd_i != RADDR_W'(RADDR_ZERO));
    in_pl.memtoreg = in_memtoreg_i;
  end

  always_comb begin
    state_d  = state_q;
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    sel_skid = 1'b0;
    unique case (1'b1)
      (state_q == ST_EMPTY): begin
        if (acc) begin
          state_d = ST_ONE;
          ld_main = 1'b1;
        end
      end
      (state_q == ST_ONE): begin
        if (acc && !pop) begin
          state_d = ST_TWO;
          ld_skid = 1'b1;
        end else if (!acc && pop) begin
          state_d = ST_EMPTY;
        end else if (acc && pop) begin
          ld_main = 1'b1;
        end
      end
      (state_q == ST_TWO): begin
        if (pop) begin
          state_d  = ST_ONE;
          ld_main  = 1'b1;
          sel_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // payload loads under flush are harmless: entries become invalid
    if (flush_i) state_d = ST_EMPTY;
  end

  assign main_d = sel_skid ? skid_q : in_pl;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  mem_wb_payload_reg #(.W(PW)) u_main (
    .clk_i (clk_i),
    .en_i  (ld_main),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  mem_wb_payload_reg #(.W(PW)) u_skid (
    .clk_i (clk_i),
    .en_i  (ld_skid),
    .d_i   (in_pl),
    .q_o   (skid_q)
  );

  // stale payload of an empty stage is masked to zero
  assign out_mem_o      = out_valid_o ? main_q.mem : '0;
  assign out_alu_o      = out_valid_o ? main_q.alu : '0;
  assign out_rd_o       = out_valid_o ? main_q.rd  : '0;
  assign out_memtoreg_o = out_valid_o & main_q.memtoreg;
  assign wb_we_o        = pop & main_q.regwrite;

`ifdef MEM_WB_FWD_EN
  assign wb_data_o  = out_memtoreg_o ? out_mem_o : out_alu_o;
  assign fwd_hit1_o = out_valid_o & main_q.regwrite &
    (main_q.rd == fwd_rs1_i);
  assign fwd_hit2_o = out_valid_o & main_q.regwrite &
    (main_q.rd == fwd_rs2_i);
`endif
endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: directed steps plus random traffic
// checked against a queue model of the buffer.
module tb_mem_wb_skid_stage;
  import mem_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [31:0] in_mem, in_alu;
  logic [4:0]  in_rd;
  logic        in_rw, in_mtr;
  logic        out_valid, out_ready;
  logic [31:0] out_mem, out_alu;
  logic [4:0]  out_rd;
  logic        out_mtr, wb_we;
`ifdef MEM_WB_FWD_EN
  logic [4:0]  rs1, rs2;
  logic [31:0] wb_data;
  logic        hit1, hit2;
`endif

  int checks   = 0;
  int failures = 0;
  mem_wb_payload_t q[$];

  always #5 clk = ~clk;

  mem_wb_skid_stage dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_mem_i       (in_mem),
    .in_alu_i       (in_alu),
    .in_rd_i        (in_rd),
    .in_regwrite_i  (in_rw),
    .in_memtoreg_i  (in_mtr),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_mem_o      (out_mem),
    .out_alu_o      (out_alu),
    .out_rd_o       (out_rd),
    .out_memtoreg_o (out_mtr),
`ifdef MEM_WB_FWD_EN
    .fwd_rs1_i      (rs1),
    .fwd_rs2_i      (rs2),
    .wb_data_o      (wb_data),
    .fwd_hit1_o     (hit1),
    .fwd_hit2_o     (hit2),
`endif
    .wb_we_o        (wb_we)
  );

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic v, logic [4:0] rd, logic rw,
                       logic mtr, logic [31:0] mem,
                       logic [31:0] alu, logic ordy, logic fl);
    in_valid  = v;
    in_rd     = rd;
    in_rw     = rw;
    in_mtr    = mtr;
    in_mem    = mem;
    in_alu    = alu;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic check_all();
    bit hv;
    hv = (q.size() != 0);
    chk("out_valid", out_valid, hv);
    chk("in_ready", in_ready, q.size() < 2);
    if (hv) begin
      chk("out_alu", out_alu, q[0].alu);
      chk("out_mem", out_mem, q[0].mem);
      chk("out_rd", out_rd, q[0].rd);
      chk("out_mtr", out_mtr, q[0].memtoreg);
      chk("wb_we", wb_we, out_ready & q[0].regwrite);
    end else begin
      chk("idle_alu", out_alu, 0);
      chk("idle_we", wb_we, 0);
    end
`ifdef MEM_WB_FWD_EN
    if (hv) begin
      chk("wb_data", wb_data,
          q[0].memtoreg ? q[0].mem : q[0].alu);
      chk("hit1", hit1, q[0].regwrite && q[0].rd == rs1);
      chk("hit2", hit2, q[0].regwrite && q[0].rd == rs2);
    end else begin
      chk("idle_hit1", hit1, 0);
      chk("idle_hit2", hit2, 0);
    end
`endif
  endtask

  // one clock: check before the edge, then advance the model
  task automatic step();
    bit acc, pop;
    mem_wb_payload_t p;
    @(negedge clk);
    check_all();
    acc = in_valid && (q.size() < 2);
    pop = (q.size() != 0) && out_ready;
    p.mem      = in_mem;
    p.alu      = in_alu;
    p.rd       = in_rd;
    p.regwrite = in_rw && (in_rd != 0);
    p.memtoreg = in_mtr;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(p);
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef MEM_WB_FWD_EN
    rs1 = 0;
    rs2 = 0;
`endif
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_alu", out_alu, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // streaming, one per cycle
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'd1, 1, 0, 32'h100 + i, 32'h10 + i, 1, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    step();

    // backpressure: A, B, stall, then drain
    drive(1, 5'd2, 1, 0, 0, 32'hAA, 0, 0);
    step();
    drive(1, 5'd2, 1, 0, 0, 32'hBB, 0, 0);
    step();
    drive(1, 5'd2, 1, 0, 0, 32'hCC, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    step();
    step();

    // x0 suppression
    drive(1, 5'd0, 1, 0, 0, 32'h55, 1, 0);
    step();
    drive(1, 5'd3, 1, 0, 0, 32'h56, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    step();

    // flush while full with incoming valid
    drive(1, 5'd4, 1, 0, 0, 32'h61, 0, 0);
    step();
    drive(1, 5'd4, 1, 0, 0, 32'h62, 0, 0);
    step();
    drive(1, 5'd4, 1, 0, 0, 32'h63, 1, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);

`ifdef MEM_WB_FWD_EN
    drive(1, 5'd7, 1, 1, 32'hDEAD, 32'h1234, 0, 0);
    rs1 = 5'd7;
    rs2 = 5'd8;
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("fwd_hit1", hit1, 1);
    chk("fwd_hit2", hit2, 0);
    chk("fwd_data", wb_data, 32'hDEAD);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    step();
    step();
`endif

    // async reset while holding two entries
    drive(1, 5'd5, 1, 0, 0, 32'h71, 0, 0);
    step();
    drive(1, 5'd5, 1, 0, 0, 32'h72, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("pre_rst_ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_alu", out_alu, 0);
    chk("arst_rd", out_rd, 0);
    chk("arst_we", wb_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // random traffic
    for (int i = 0; i < 500; i++) begin
      drive(($urandom % 4) != 0, 5'($urandom % 4),
            1'($urandom), 1'($urandom), $urandom, $urandom,
            ($urandom % 3) != 0, ($urandom % 32) == 0);
`ifdef MEM_WB_FWD_EN
      rs1 = 5'($urandom % 4);
      rs2 = 5'($urandom % 4);
`endif
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
